sw_time_record: RTL and testbench

Centisecond-resolution stopwatch time base with an integrated 16-entry lap/record register file. A BCD counter chain (centiseconds 00–99, seconds 00–59, minutes 00–59) advances on an externally supplied 100 Hz tick while enabled. Any count can be stored into, or read back from, one of 16 record slots. The block sits between the stopwatch control logic, which supplies run/clear/record commands, and the 7-segment display mux, which consumes `time_bcd` or `rd_data`.

---
 rtl/sw_time_record.sv | 82 ++++++++
 tb/tb_sw_time_record.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sw_time_record.sv
// Stopwatch time base: BCD mm:ss.cc counter advanced by a 100 Hz tick,
// with a 16 x 24-bit lap record file (async-reset, combinational read).
module sw_time_record (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        run,
    input  logic        clear,
    input  logic        rec_wr,
    input  logic [3:0]  addr,
    output logic [23:0] time_bcd,
    output logic [23:0] rd_data,
    output logic        sec_carry,
    output logic        min_carry,
    output logic        wrap
);

    logic [23:0] time_q;
    logic [23:0] time_nxt;
    logic [23:0] mem [16];

    logic [3:0] cs_l, cs_h, sec_l, sec_h, min_l, min_h;
    logic [3:0] cs_l_n, cs_h_n, sec_l_n, sec_h_n, min_l_n, min_h_n;
    logic       inc, cs_h_en, cs_roll, sec_h_en, sec_roll, min_h_en, min_roll;

    assign {min_h, min_l, sec_h, sec_l, cs_h, cs_l} = time_q;
    assign time_bcd = time_q;
    assign rd_data  = mem[addr];

    // Digit-by-digit carry chain; each digit advances only when all lower digits roll.
    always_comb begin
        inc      = tick & run & ~clear;
        cs_h_en  = inc & (cs_l >= 4'd9);
        cs_roll  = cs_h_en & (cs_h >= 4'd9);
        sec_h_en = cs_roll & (sec_l >= 4'd9);
        sec_roll = sec_h_en & (sec_h >= 4'd5);
        min_h_en = sec_roll & (min_l >= 4'd9);
        min_roll = min_h_en & (min_h >= 4'd5);

        cs_l_n  = cs_l;
        cs_h_n  = cs_h;
        sec_l_n = sec_l;
        sec_h_n = sec_h;
        min_l_n = min_l;
        min_h_n = min_h;

        if (inc)      cs_l_n  = (cs_l  >= 4'd9) ? 4'd0 : cs_l  + 4'd1;
        if (cs_h_en)  cs_h_n  = (cs_h  >= 4'd9) ? 4'd0 : cs_h  + 4'd1;
        if (cs_roll)  sec_l_n = (sec_l >= 4'd9) ? 4'd0 : sec_l + 4'd1;
        if (sec_h_en) sec_h_n = (sec_h >= 4'd5) ? 4'd0 : sec_h + 4'd1;
        if (sec_roll) min_l_n = (min_l >= 4'd9) ? 4'd0 : min_l + 4'd1;
        if (min_h_en) min_h_n = (min_h >= 4'd5) ? 4'd0 : min_h + 4'd1;

        if (clear) time_nxt = '0;
        else       time_nxt = {min_h_n, min_l_n, sec_h_n, sec_l_n, cs_h_n, cs_l_n};
    end

    // Time register and one-cycle rollover pulses aligned with the rolled value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_q    <= '0;
            sec_carry <= 1'b0;
            min_carry <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            time_q    <= time_nxt;
            sec_carry <= cs_roll;
            min_carry <= sec_roll;
            wrap      <= min_roll;
        end
    end

    // Record file captures the pre-edge time; reset wipes every slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
        end else if (rec_wr) begin
            mem[addr] <= time_q;
        end
    end

endmodule

// File: tb/tb_sw_time_record.sv
// Directed scoreboard bench for sw_time_record.
module tb_sw_time_record;

    logic        clk = 1'b0;
    logic        reset_n, tick, run, clear, rec_wr;
    logic [3:0]  addr;
    logic [23:0] time_bcd, rd_data;
    logic        sec_carry, min_carry, wrap;

    sw_time_record dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .run(run), .clear(clear),
        .rec_wr(rec_wr), .addr(addr), .time_bcd(time_bcd), .rd_data(rd_data),
        .sec_carry(sec_carry), .min_carry(min_carry), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] t;
        logic [23:0] rd;
        logic        sc, mc, w;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] m_time;
    logic [23:0] m_mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int to_cs(input logic [23:0] t);
        return (int'(t[23:20]) * 10 + int'(t[19:16])) * 6000 +
               (int'(t[15:12]) * 10 + int'(t[11:8])) * 100 +
               int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic logic [23:0] from_cs(input int n);
        int mi, se, cs;
        mi = n / 6000; se = (n / 100) % 60; cs = n % 100;
        return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".time"}, time_bcd, e.t);
        chk({e.tag, ".rd"}, rd_data, e.rd);
        chk({e.tag, ".sec_carry"}, {23'd0, sec_carry}, {23'd0, e.sc});
        chk({e.tag, ".min_carry"}, {23'd0, min_carry}, {23'd0, e.mc});
        chk({e.tag, ".wrap"}, {23'd0, wrap}, {23'd0, e.w});
    endtask

    // One clock cycle: drive at negedge, predict, compare 1 ns after posedge.
    task automatic step(input logic tk, input logic rn, input logic cl,
                        input logic wr, input logic [3:0] a, input string tag);
        exp_t e;
        int   n;
        logic inc;
        @(negedge clk);
        tick = tk; run = rn; clear = cl; rec_wr = wr; addr = a;
        inc = tk & rn & ~cl;
        n = to_cs(m_time);
        e.sc = inc && (n % 100 == 99);
        e.mc = inc && (n % 6000 == 5999);
        e.w  = inc && (n == 359999);
        if (wr) m_mem[a] = m_time;
        if (cl)       m_time = '0;
        else if (inc) m_time = from_cs((n + 1) % 360000);
        e.t = m_time; e.rd = m_mem[a]; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    // Combinational read of a slot without a clock edge.
    task automatic rd_check(input logic [3:0] a, input string tag);
        exp_t e;
        addr = a;
        e.t = m_time; e.rd = m_mem[a]; e.sc = 1'b0; e.mc = 1'b0; e.w = 1'b0; e.tag = tag;
        sb.push_back(e);
        #1;
        pop_compare();
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; run = 1'b0; clear = 1'b0; rec_wr = 1'b0; addr = '0;
        m_time = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;

        #2;
        for (int i = 0; i < 16; i++) rd_check(4'(i), "reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 100 increments -> 00:01.00 with one sec_carry; continue to 00:59.99, then minute carry
        repeat (100)  step(1, 1, 0, 0, 0, "count100");
        chk("at_100", time_bcd, 24'h000100);
        repeat (5899) step(1, 1, 0, 0, 0, "count5999");
        chk("at_5999", time_bcd, 24'h005999);
        step(1, 1, 0, 0, 0, "min_roll");
        chk("at_6000", time_bcd, 24'h010000);
        step(1, 1, 0, 0, 0, "after_min_roll");

        // clear overrides tick/run; pause holds the count
        step(1, 1, 1, 0, 0, "clear");
        repeat (42) step(1, 1, 0, 0, 0, "to42");
        repeat (20) step(1, 0, 0, 0, 0, "paused");
        chk("hold_42", time_bcd, 24'h000042);
        step(1, 1, 0, 0, 0, "resume");
        chk("at_43", time_bcd, 24'h000043);
        repeat (1191) step(1, 1, 0, 0, 0, "to1234");
        chk("at_1234", time_bcd, 24'h001234);

        // record with a simultaneous increment stores the pre-increment value
        step(1, 1, 0, 1, 3, "rec3");
        step(0, 0, 0, 0, 3, "rec3_hold");
        for (int i = 0; i < 16; i++) rd_check(4'(i), "slots_after_rec3");

        // fill every slot with distinct running values, then clear the counter
        for (int i = 0; i < 16; i++) step(1, 1, 0, 1, 4'(i), "fill");
        step(0, 1, 1, 0, 0, "clear_keep_mem");
        for (int i = 0; i < 16; i++) rd_check(4'(i), "slots_after_clear");

        // preload near the end of the range (paused) and count through full rollover
        @(negedge clk);
        run = 1'b0; tick = 1'b0; rec_wr = 1'b0;
        force dut.time_q = 24'h595950;
        @(posedge clk);
        #1;
        release dut.time_q;
        m_time = 24'h595950;
        repeat (49) step(1, 1, 0, 0, 0, "to595999");
        chk("at_595999", time_bcd, 24'h595999);
        step(1, 1, 0, 0, 0, "wrap");
        step(1, 1, 0, 0, 0, "after_wrap");

        // reset in the middle of a write: everything reads zero at once
        @(negedge clk);
        tick = 1'b1; run = 1'b1; rec_wr = 1'b1; addr = 4'd5;
        #2;
        reset_n = 1'b0;
        m_time = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        for (int i = 0; i < 16; i++) rd_check(4'(i), "mid_reset");
        @(negedge clk);
        tick = 1'b0; run = 1'b0; rec_wr = 1'b0;
        reset_n = 1'b1;
        repeat (3) step(1, 1, 0, 0, 5, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
